outfifo_merger: RTL and testbench
=================================

OUTFIFO_MERGER -- requirements
Module: outfifo_merger

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 8, number of thread output FIFOs; legal range 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, packet word width.
REQ-003 SHALL have parameter CTRL_WIDTH, default 8, control word width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port thread_pkt_avail  input  NUM_THREADS  thread i holds at least one complete packet.
REQ-007 SHALL have port thread_empty  input  NUM_THREADS  thread i FIFO empty.
REQ-008 SHALL have port thread_data  input  NUM_THREADS*DATA_WIDTH  FIFO head words; thread i at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port thread_ctrl  input  NUM_THREADS*CTRL_WIDTH  FIFO head ctrl; thread i at slice [i*CTRL_WIDTH +: CTRL_WIDTH].
REQ-010 SHALL have port thread_lastword  input  NUM_THREADS  head word of thread i is the packet's last word.
REQ-011 SHALL have port thread_rd_en  output  NUM_THREADS  read strobe to thread i FIFO; one-cycle read latency.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  merged output word.
REQ-013 SHALL have port out_ctrl  output  CTRL_WIDTH  merged output ctrl.
REQ-014 SHALL have port out_wr  output  1  out_data/out_ctrl valid this cycle.
REQ-015 SHALL have port out_rdy  input  1  downstream can accept a word next cycle.
REQ-016 SHALL have port grant_thread  output  3  currently granted thread index.
REQ-017 SHALL have port thread_release  output  NUM_THREADS  one-cycle pulse when thread i's packet has fully left.

Function
REQ-018 SHALL implement FSM states IDLE, XFER.
REQ-019 IDLE: if any thread_pkt_avail bit is set, SHALL grant the first set bit searching upward from (last_grant+1) mod NUM_THREADS, load grant_thread and last_grant, and enter XFER next cycle.
REQ-020 XFER: thread_rd_en[grant_thread] SHALL be asserted iff out_rdy=1 and thread_empty[grant_thread]=0; all other rd_en bits SHALL be 0.
REQ-021 A read issued in cycle N SHALL produce out_wr=1 with that word's data/ctrl registered in cycle N+1 (latency 1).
REQ-022 When a read is issued with thread_lastword[grant_thread]=1, the FSM SHALL return to IDLE in the next cycle; no further reads on that thread in the current grant.
REQ-023 thread_release[grant] SHALL pulse in the same cycle out_wr carries the last word.
REQ-024 Minimum gap between packets: one cycle without out_wr (IDLE arbitration cycle).
REQ-025 out_rdy=0 or empty mid-packet SHALL stall reads without losing grant; out_wr=0 while stalled.
REQ-026 thread_pkt_avail changes during XFER SHALL not affect the active grant.
REQ-027 out_data/out_ctrl SHALL hold their last value when out_wr=0.

Reset
REQ-028 On reset: state=IDLE, last_grant=NUM_THREADS-1 (thread 0 highest priority first), grant_thread=0, thread_rd_en=0, out_wr=0, out_data=0, out_ctrl=0, thread_release=0.
REQ-029 Reset mid-packet SHALL abandon the packet immediately; no release pulse for it.

Configuration
REQ-030 Macro OUTFIFO_MERGER_PKT_COUNT_EN: when defined, SHALL add input count_sel (3 bits) and output pkt_count (16 bits) giving packets released by thread count_sel, incremented on each thread_release pulse, wrapping 0xFFFF->0, cleared by reset, readout combinational; when undefined, these ports and counters SHALL not exist.

Verification
REQ-031 Reset, thread 2 avail with 3-word packet, out_rdy=1 -> rd_en[2] 3 consecutive cycles, out_wr 3 words one cycle later, release[2] with third word, grant_thread=2.
REQ-032 All threads avail simultaneously after reset, 1-word packets -> grants in order 0,1,2..7, each separated by one idle cycle.
REQ-033 Thread 5 granted, out_rdy dropped for 4 cycles mid-packet -> no rd_en, no out_wr during stall, packet completes intact in order.
REQ-034 Thread 1 FIFO empty for 2 cycles mid-packet while thread 3 avail -> grant stays on 1 until its last word; then thread 3 granted.
REQ-035 Reset asserted in XFER after 2 of 5 words -> next cycle all outputs at reset values; after release thread 0 wins first if avail.
REQ-036 With OUTFIFO_MERGER_PKT_COUNT_EN, 3 packets from thread 4, count_sel=4 -> pkt_count=3; count_sel=0 -> 0.

Source files
------------

// File: rtl/outfifo_merger.sv
// outfifo_merger: round-robin merge of per-thread packet FIFOs into one output word stream.
// Defining OUTFIFO_MERGER_PKT_COUNT_EN adds per-thread released-packet counters (count_sel / pkt_count).
module outfifo_merger #(
    parameter int NUM_THREADS = 8,
    parameter int DATA_WIDTH  = 64,
    parameter int CTRL_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
`ifdef OUTFIFO_MERGER_PKT_COUNT_EN
    input  logic [2:0]                        count_sel,
    output logic [15:0]                       pkt_count,
`endif
    input  logic [NUM_THREADS-1:0]            thread_pkt_avail,
    input  logic [NUM_THREADS-1:0]            thread_empty,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] thread_data,
    input  logic [NUM_THREADS*CTRL_WIDTH-1:0] thread_ctrl,
    input  logic [NUM_THREADS-1:0]            thread_lastword,
    output logic [NUM_THREADS-1:0]            thread_rd_en,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [CTRL_WIDTH-1:0]             out_ctrl,
    output logic                              out_wr,
    input  logic                              out_rdy,
    output logic [2:0]                        grant_thread,
    output logic [NUM_THREADS-1:0]            thread_release
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [2:0]              last_grant;
    logic [2:0]              pick;
    logic                    any_avail;
    logic                    cur_empty;
    logic                    cur_last;
    logic [DATA_WIDTH-1:0]   cur_data;
    logic [CTRL_WIDTH-1:0]   cur_ctrl;
    logic                    rd_fire;

    // Head-of-FIFO view of the currently granted thread
    always_comb begin
        cur_empty = 1'b1;
        cur_last  = 1'b0;
        cur_data  = '0;
        cur_ctrl  = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            cur_empty = (grant_thread == 3'(i)) ? thread_empty[i]    : cur_empty;
            cur_last  = (grant_thread == 3'(i)) ? thread_lastword[i] : cur_last;
            cur_data  = (grant_thread == 3'(i)) ? thread_data[i*DATA_WIDTH +: DATA_WIDTH] : cur_data;
            cur_ctrl  = (grant_thread == 3'(i)) ? thread_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH] : cur_ctrl;
        end
    end

    // Round-robin pick: smallest distance above last_grant wins
    always_comb begin
        int best_d;
        int d;
        logic take;
        pick      = last_grant;
        any_avail = |thread_pkt_avail;
        best_d    = NUM_THREADS;
        d         = 0;
        take      = 1'b0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            d      = (i + NUM_THREADS - 1 - int'(last_grant)) % NUM_THREADS;
            take   = thread_pkt_avail[i] && (d < best_d);
            best_d = take ? d : best_d;
            pick   = take ? 3'(i) : pick;
        end
    end

    // Read strobe and next-state decode
    always_comb begin
        rd_fire      = (state == XFER) && out_rdy && !cur_empty && !reset;
        thread_rd_en = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            thread_rd_en[i] = rd_fire && (grant_thread == 3'(i));
        end
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_avail) begin
                    state_nxt = XFER;
                end else begin
                    state_nxt = IDLE;
                end
            end
            XFER: begin
                if (rd_fire && cur_last) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = XFER;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant and registered output stage
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= 3'(NUM_THREADS - 1);
            grant_thread   <= 3'd0;
            out_wr         <= 1'b0;
            out_data       <= '0;
            out_ctrl       <= '0;
            thread_release <= '0;
        end else begin
            state  <= state_nxt;
            out_wr <= rd_fire;
            if ((state == IDLE) && any_avail) begin
                grant_thread <= pick;
                last_grant   <= pick;
            end
            if (rd_fire) begin
                out_data <= cur_data;
                out_ctrl <= cur_ctrl;
            end
            // the granted rd_en bit doubles as the one-hot release mask
            thread_release <= cur_last ? thread_rd_en : '0;
        end
    end

`ifdef OUTFIFO_MERGER_PKT_COUNT_EN
    logic [15:0] pkt_cnt [NUM_THREADS];

    // Per-thread released-packet counters, wrapping naturally at 16 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                pkt_cnt[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                pkt_cnt[i] <= thread_release[i] ? pkt_cnt[i] + 16'd1 : pkt_cnt[i];
            end
        end
    end

    // Counter readout mux; out-of-range selects read as zero
    always_comb begin
        pkt_count = 16'd0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            pkt_count = (count_sel == 3'(i)) ? pkt_cnt[i] : pkt_count;
        end
    end
`endif

endmodule

// File: tb/tb_outfifo_merger.sv
// Self-checking bench for outfifo_merger: packet-level FIFO/arbitration reference model,
// a table of single-packet scenarios, directed corner sequences and randomized traffic.
module tb_outfifo_merger;
    localparam int N  = 8;
    localparam int DW = 64;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, out_rdy, out_wr;
    logic [N-1:0]    thread_pkt_avail, thread_empty, thread_lastword, thread_rd_en, thread_release;
    logic [N*DW-1:0] thread_data;
    logic [N*CW-1:0] thread_ctrl;
    logic [DW-1:0]   out_data;
    logic [CW-1:0]   out_ctrl;
    logic [2:0]      grant_thread;
`ifdef OUTFIFO_MERGER_PKT_COUNT_EN
    logic [2:0]      count_sel;
    logic [15:0]     pkt_count;
`endif

    outfifo_merger #(.NUM_THREADS(N), .DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
`ifdef OUTFIFO_MERGER_PKT_COUNT_EN
        .count_sel(count_sel), .pkt_count(pkt_count),
`endif
        .thread_pkt_avail(thread_pkt_avail), .thread_empty(thread_empty),
        .thread_data(thread_data), .thread_ctrl(thread_ctrl),
        .thread_lastword(thread_lastword), .thread_rd_en(thread_rd_en),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .grant_thread(grant_thread), .thread_release(thread_release)
    );

    typedef struct { logic [DW-1:0] d; logic [CW-1:0] c; logic last; } word_t;
    typedef struct { int thr; int words; int stall; int exp_grant; int exp_lat; } vec_t;

    word_t fifo [N][$];
    int    hold [N];
    int    n_pass = 0;
    int    n_total = 0;
    logic  rst_q = 1'b1;
    logic  rdy_q = 1'b1;

    // reference model: packet-level view of the merger
    logic          m_busy;
    int            m_cur;
    int            m_last;
    logic [2:0]    m_grant;
    logic          m_wr;
    logic [DW-1:0] m_data;
    logic [CW-1:0] m_ctrl;
    logic [N-1:0]  m_rel;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_cur = 0; m_last = N - 1; m_grant = 3'd0;
        m_wr = 1'b0; m_data = '0; m_ctrl = '0; m_rel = '0;
    endtask

    function automatic logic has_pkt(input int t);
        foreach (fifo[t][j]) if (fifo[t][j].last) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] av);
        for (int k = 1; k <= N; k++) if (av[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic push_pkt(input int t, input int len);
        word_t w;
        for (int k = 0; k < len; k++) begin
            w.d = {$urandom, $urandom};
            w.c = 8'($urandom);
            w.last = (k == len - 1);
            fifo[t].push_back(w);
        end
    endtask

    // one clock: drive at negedge, compare, then advance the model across the next posedge
    task automatic step();
        logic [N-1:0] exp_rd;
        word_t w;
        int p;
        @(negedge clk);
        reset = rst_q;
        out_rdy = rdy_q;
        for (int i = 0; i < N; i++) begin
            thread_empty[i]     = (fifo[i].size() == 0) || (hold[i] > 0);
            thread_pkt_avail[i] = has_pkt(i);
            thread_data[i*DW +: DW] = (fifo[i].size() > 0) ? fifo[i][0].d : '0;
            thread_ctrl[i*CW +: CW] = (fifo[i].size() > 0) ? fifo[i][0].c : '0;
            thread_lastword[i]  = (fifo[i].size() > 0) && fifo[i][0].last;
        end
        #1;
        chk("out_wr", 64'(out_wr), 64'(m_wr));
        chk("out_data", out_data, m_data);
        chk("out_ctrl", 64'(out_ctrl), 64'(m_ctrl));
        chk("release", 64'(thread_release), 64'(m_rel));
        chk("grant", 64'(grant_thread), 64'(m_grant));
        exp_rd = '0;
        if (!reset && m_busy && out_rdy && !thread_empty[m_cur]) exp_rd[m_cur] = 1'b1;
        if (!reset) chk("rd_en", 64'(thread_rd_en), 64'(exp_rd));
        if (reset) begin
            model_reset();
        end else begin
            m_wr = 1'b0;
            m_rel = '0;
            if (m_busy) begin
                if (exp_rd != '0) begin
                    w = fifo[m_cur].pop_front();
                    m_wr = 1'b1; m_data = w.d; m_ctrl = w.c;
                    if (w.last) begin m_rel[m_cur] = 1'b1; m_busy = 1'b0; end
                end
            end else begin
                p = rr_pick(m_last, thread_pkt_avail);
                if (p >= 0) begin m_busy = 1'b1; m_cur = p; m_last = p; m_grant = 3'(p); end
            end
        end
        for (int i = 0; i < N; i++) if (hold[i] > 0) hold[i]--;
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin fifo[i].delete(); hold[i] = 0; end
        rst_q = 1'b1; rdy_q = 1'b1;
        step(); step();
        rst_q = 1'b0;
    endtask

    // runs until n releases were seen or the budget expires; records order and cycle
    int rel_thr [$];
    int rel_cyc [$];
    task automatic collect(input int n, input int budget, input string nm);
        rel_thr.delete(); rel_cyc.delete();
        for (int c = 1; c <= budget && rel_thr.size() < n; c++) begin
            step();
            for (int i = 0; i < N; i++) if (thread_release[i]) begin rel_thr.push_back(i); rel_cyc.push_back(c); end
        end
        chk({nm, "_count"}, 64'(rel_thr.size()), 64'(n));
    endtask

    initial begin
        vec_t vecs [4];
        int got;
        vecs[0] = '{thr: 2, words: 3, stall: 0, exp_grant: 2, exp_lat: 5};
        vecs[1] = '{thr: 5, words: 4, stall: 4, exp_grant: 5, exp_lat: 10};
        vecs[2] = '{thr: 0, words: 1, stall: 0, exp_grant: 0, exp_lat: 3};
        vecs[3] = '{thr: 7, words: 2, stall: 1, exp_grant: 7, exp_lat: 5};

        reset = 1'b1; out_rdy = 1'b0;
        thread_pkt_avail = '0; thread_empty = '1; thread_data = '0; thread_ctrl = '0; thread_lastword = '0;
`ifdef OUTFIFO_MERGER_PKT_COUNT_EN
        count_sel = 3'd0;
`endif
        for (int i = 0; i < N; i++) hold[i] = 0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();
        chk("rst_out_wr", 64'(out_wr), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_grant", 64'(grant_thread), 64'd0);
        chk("rst_release", 64'(thread_release), 64'd0);

        // single-packet scenarios with optional out_rdy stall after the first read
        for (int v = 0; v < 4; v++) begin
            push_pkt(vecs[v].thr, vecs[v].words);
            got = -1;
            for (int c = 1; c <= 40; c++) begin
                rdy_q = !(c >= 3 && c < 3 + vecs[v].stall);
                step();
                if (thread_release[vecs[v].thr]) begin got = c; break; end
            end
            rdy_q = 1'b1;
            chk("vec_latency", 64'(got), 64'(vecs[v].exp_lat));
            chk("vec_grant", 64'(grant_thread), 64'(vecs[v].exp_grant));
            step(); step();
        end

        // every thread ready with a 1-word packet: strict round-robin, one idle cycle between packets
        do_reset();
        for (int t = 0; t < N; t++) push_pkt(t, 1);
        collect(N, 60, "rr");
        for (int k = 0; k < rel_thr.size(); k++) begin
            chk("rr_order", 64'(rel_thr[k]), 64'(k));
            if (k > 0) chk("rr_gap", 64'(rel_cyc[k] - rel_cyc[k-1]), 64'd2);
        end

        // thread 1 runs dry mid-packet while thread 3 waits
        do_reset();
        push_pkt(1, 4);
        push_pkt(3, 1);
        step(); step(); step();
        hold[1] = 2;
        collect(2, 40, "empty_stall");
        if (rel_thr.size() == 2) begin
            chk("empty_first", 64'(rel_thr[0]), 64'd1);
            chk("empty_second", 64'(rel_thr[1]), 64'd3);
        end

        // reset after 2 of 5 words; thread 0 then wins over the abandoned thread's remainder
        do_reset();
        push_pkt(3, 5);
        step(); step(); step();
        rst_q = 1'b1;
        step();
        rst_q = 1'b0;
        push_pkt(0, 1);
        step();
        chk("midrst_out_wr", 64'(out_wr), 64'd0);
        chk("midrst_release", 64'(thread_release), 64'd0);
        chk("midrst_grant", 64'(grant_thread), 64'd0);
        collect(2, 40, "midrst");
        if (rel_thr.size() == 2) begin
            chk("midrst_first", 64'(rel_thr[0]), 64'd0);
            chk("midrst_second", 64'(rel_thr[1]), 64'd3);
        end

`ifdef OUTFIFO_MERGER_PKT_COUNT_EN
        do_reset();
        for (int k = 0; k < 3; k++) push_pkt(4, 1 + k);
        collect(3, 60, "cnt");
        count_sel = 3'd4;
        #1 chk("pkt_count4", 64'(pkt_count), 64'd3);
        count_sel = 3'd0;
        #1 chk("pkt_count0", 64'(pkt_count), 64'd0);
`endif

        // randomized traffic, stalls, empty holes and occasional resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rdy_q = ($urandom_range(3, 0) != 0);
            rst_q = ($urandom_range(599, 0) == 0);
            if ($urandom_range(5, 0) == 0) begin
                got = $urandom_range(N - 1, 0);
                if (fifo[got].size() < 24) push_pkt(got, $urandom_range(5, 1));
            end
            if ($urandom_range(15, 0) == 0) hold[$urandom_range(N - 1, 0)] = $urandom_range(3, 1);
            step();
        end
        rst_q = 1'b0; rdy_q = 1'b1;
        repeat (400) step();
        got = 0;
        for (int i = 0; i < N; i++) got += fifo[i].size();
        chk("drained", 64'(got), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
